tdm_mux_scanner: RTL and testbench

- Parametrised, registered N-channel time-division multiplexer. Successor to the combinational 8:1 mux.
- Adds multi-bit channels, a registered output with valid/ready backpressure, an auto-scan mode with a per-channel dwell count, a channel enable mask, and a scan-wrap pulse.
- Sits between a bank of parallel sample sources and a single serial consumer, such as a logger or UART framer.

---
 rtl/tdm_mux_scanner.sv | 145 ++++++++++++++
 tb/tb_tdm_mux_scanner.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux_scanner.sv
// Registered N-channel time-division multiplexer with manual select, auto-scan
// with per-channel dwell, channel enable mask, valid/ready output and wrap pulse.
module tdm_mux_scanner #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DWELL = 4,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      man_sel,
    input  logic [N_CH-1:0]       ch_mask,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  wrap
);

    localparam int unsigned DW_W = $clog2(DWELL + 1);

    localparam logic [1:0] S_MAN  = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic             wrap_q, wrap_d;
    logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
    logic [DW_W-1:0]  dwell_cnt_q, dwell_cnt_d;

    logic [SEL_W-1:0] nxt_ch;
    logic             load;
    logic             mode_chg;
    logic             advance;
    logic [DW_W-1:0]  dwell_base;
    int unsigned      ms;

    // Nearest enabled channel after cur_ch, searching upward modulo N_CH.
    always_comb begin
        logic found;
        found  = 1'b0;
        nxt_ch = cur_ch_q;
        for (int d = 1; d <= int'(N_CH); d++) begin
            int unsigned idx;
            idx = (int'(cur_ch_q) + d) % N_CH;
            if (!found && ch_mask[idx]) begin
                nxt_ch = SEL_W'(idx);
                found  = 1'b1;
            end
        end
    end

    // Next-state: mode decode, output load, dwell counting and channel advance.
    always_comb begin
        state_d     = !mode ? S_MAN : ((ch_mask == '0) ? S_IDLE : S_SCAN);
        // Only manual <-> auto transitions count as a mode change; IDLE <-> SCAN does not.
        mode_chg    = (state_q == S_MAN) != (state_d == S_MAN);
        load        = !out_valid_q || out_ready;
        dwell_base  = mode_chg ? '0 : dwell_cnt_q;
        ms          = int'(man_sel);
        advance     = 1'b0;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        cur_ch_d    = cur_ch_q;
        dwell_cnt_d = dwell_base;
        wrap_d      = 1'b0;

        if (load) begin
            case (state_d)
                S_MAN: begin
                    out_sel_d = man_sel;
                    if (ms < N_CH) begin
                        out_data_d  = in_data[ms*WIDTH +: WIDTH];
                        out_valid_d = ch_mask[ms];
                    end else begin
                        out_data_d  = '0;
                        out_valid_d = 1'b0;
                    end
                end
                S_IDLE: begin
                    out_valid_d = 1'b0;
                end
                S_SCAN: begin
                    if (ch_mask[cur_ch_q]) begin
                        out_data_d  = in_data[int'(cur_ch_q)*WIDTH +: WIDTH];
                        out_sel_d   = cur_ch_q;
                        out_valid_d = 1'b1;
                        if (dwell_base == DW_W'(DWELL - 1)) begin
                            advance     = 1'b1;
                            dwell_cnt_d = '0;
                        end else begin
                            dwell_cnt_d = dwell_base + 1'b1;
                        end
                    end else begin
                        // Channel masked mid-dwell or at entry: skip without emitting.
                        out_valid_d = 1'b0;
                        advance     = 1'b1;
                        dwell_cnt_d = '0;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                end
            endcase
        end

        if (advance) begin
            cur_ch_d = nxt_ch;
            wrap_d   = (nxt_ch <= cur_ch_q);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_MAN;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            cur_ch_q    <= '0;
            dwell_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            wrap_q      <= wrap_d;
            cur_ch_q    <= cur_ch_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_tdm_mux_scanner.sv
// Directed self-checking bench for tdm_mux_scanner; four instances with different
// DWELL / N_CH share one stimulus stream, each phase checks the relevant instance.
module tb_tdm_mux_scanner;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_data;
    logic        mode;
    logic [2:0]  man_sel;
    logic [7:0]  ch_mask;
    logic        out_ready;

    logic [7:0] a_data, b_data, c_data, d_data;
    logic [2:0] a_sel, b_sel, c_sel, d_sel;
    logic       a_valid, b_valid, c_valid, d_valid;
    logic       a_wrap, b_wrap, c_wrap, d_wrap;

    int n_checks;
    int n_err;

    tdm_mux_scanner #(.N_CH(8), .WIDTH(8), .DWELL(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .mode(mode), .man_sel(man_sel),
        .ch_mask(ch_mask), .out_data(a_data), .out_sel(a_sel), .out_valid(a_valid),
        .out_ready(out_ready), .wrap(a_wrap)
    );

    tdm_mux_scanner #(.N_CH(8), .WIDTH(8), .DWELL(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .mode(mode), .man_sel(man_sel),
        .ch_mask(ch_mask), .out_data(b_data), .out_sel(b_sel), .out_valid(b_valid),
        .out_ready(out_ready), .wrap(b_wrap)
    );

    tdm_mux_scanner #(.N_CH(8), .WIDTH(8), .DWELL(3)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .mode(mode), .man_sel(man_sel),
        .ch_mask(ch_mask), .out_data(c_data), .out_sel(c_sel), .out_valid(c_valid),
        .out_ready(out_ready), .wrap(c_wrap)
    );

    tdm_mux_scanner #(.N_CH(5), .WIDTH(8), .DWELL(1)) u_d (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[39:0]), .mode(mode), .man_sel(man_sel),
        .ch_mask(ch_mask[4:0]), .out_data(d_data), .out_sel(d_sel), .out_valid(d_valid),
        .out_ready(out_ready), .wrap(d_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        mode      = 1'b0;
        man_sel   = '0;
        ch_mask   = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'h10 + 8'(k);
        tick();

        // Reset state
        check("rst_data", a_data, 0);
        check("rst_sel", a_sel, 0);
        check("rst_valid", a_valid, 0);
        check("rst_wrap", a_wrap, 0);

        // Manual sweep: bit 0 of channel k alternates 0,1,0,1...
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            man_sel = 3'(k);
            tick();
            check("man_data", a_data, 32'h10 + k);
            check("man_bit0", a_data[0], k % 2);
            check("man_sel", a_sel, k);
            check("man_valid", a_valid, 1);
        end
        man_sel = 3'd3;
        ch_mask = 8'hF7;
        tick();
        check("man_masked_valid", a_valid, 0);
        ch_mask = 8'hFF;

        // Auto-scan DWELL=2: each channel twice, wrap in the cycle after the ch7 advance
        do_reset();
        mode = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            check("scan_sel", a_sel, (i / 2) % 8);
            check("scan_data", a_data, 32'h10 + (i / 2) % 8);
            check("scan_valid", a_valid, 1);
            check("scan_wrap", a_wrap, (i == 15) ? 1 : 0);
        end

        // Backpressure mid-dwell on ch1
        tick();
        check("bp_pre_sel", a_sel, 1);
        out_ready = 1'b0;
        in_data[15:8] = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_sel", a_sel, 1);
            check("bp_hold_data", a_data, 32'h11);
            check("bp_hold_valid", a_valid, 1);
        end
        in_data[15:8] = 8'h11;
        out_ready = 1'b1;
        tick();
        check("bp_resume0", a_sel, 1);
        tick();
        check("bp_resume1", a_sel, 2);
        tick();
        check("bp_resume2", a_sel, 2);
        tick();
        check("bp_resume3", a_sel, 3);

        // Empty mask in auto mode
        ch_mask = 8'h00;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("idle_valid", a_valid, 0);
            check("idle_wrap", a_wrap, 0);
        end
        ch_mask = 8'hFF;

        // Reset mid-scan at cur_ch=5, dwell_cnt=1
        do_reset();
        for (int i = 0; i < 11; i++) tick();
        check("mid_sel5", a_sel, 5);
        rst_n = 1'b0;
        tick();
        check("mid_rst_data", a_data, 0);
        check("mid_rst_sel", a_sel, 0);
        check("mid_rst_valid", a_valid, 0);
        check("mid_rst_wrap", a_wrap, 0);
        rst_n = 1'b1;
        tick();
        check("restart_sel", a_sel, 0);
        check("restart_data", a_data, 32'h10);
        check("restart_valid", a_valid, 1);
        tick();
        check("restart_sel_b", a_sel, 0);
        tick();
        check("restart_sel_c", a_sel, 1);

        // Masking, DWELL=1, mask 1000_0101
        mode = 1'b0;
        do_reset();
        ch_mask = 8'b1000_0101;
        mode = 1'b1;
        tick();
        check("mask_s0", b_sel, 0);
        check("mask_w0", b_wrap, 0);
        tick();
        check("mask_s1", b_sel, 2);
        check("mask_d1", b_data, 32'h12);
        check("mask_w1", b_wrap, 0);
        tick();
        check("mask_s2", b_sel, 7);
        check("mask_w2", b_wrap, 1);
        tick();
        check("mask_s3", b_sel, 0);
        check("mask_w3", b_wrap, 0);
        ch_mask = 8'b1000_0001;
        tick();
        check("mask_skip_valid", b_valid, 0);
        check("mask_skip_wrap", b_wrap, 0);
        tick();
        check("mask_after_sel", b_sel, 7);
        check("mask_after_valid", b_valid, 1);
        check("mask_after_wrap", b_wrap, 1);
        tick();
        check("mask_after_s0", b_sel, 0);

        // Single enabled channel 3, DWELL=3
        mode = 1'b0;
        do_reset();
        ch_mask = 8'h08;
        mode = 1'b1;
        tick();
        check("single_entry_valid", c_valid, 0);
        check("single_entry_wrap", c_wrap, 0);
        for (int t = 2; t <= 7; t++) begin
            tick();
            check("single_sel", c_sel, 3);
            check("single_data", c_data, 32'h13);
            check("single_valid", c_valid, 1);
            check("single_wrap", c_wrap, (t == 4 || t == 7) ? 1 : 0);
        end

        // Out-of-range manual select on N_CH=5
        mode = 1'b0;
        ch_mask = 8'hFF;
        man_sel = 3'd6;
        tick();
        check("oor_valid", d_valid, 0);
        check("oor_data", d_data, 0);
        check("oor_sel", d_sel, 6);
        check("oor_wrap", d_wrap, 0);
        man_sel = 3'd4;
        tick();
        check("inr_valid", d_valid, 1);
        check("inr_data", d_data, 32'h14);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
